// File: rtl/matmul_sequencer_pkg.sv
// Shared encodings for the matmul sequencer: FSM state codes, phase-pulse and
// status bit positions, base-register slots and the watchdog width helper.
package matmul_sequencer_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FILL    = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_NEXT    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERR     = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_FILL    = S_FILL,
        ST_LOAD    = S_LOAD,
        ST_COMPUTE = S_COMPUTE,
        ST_NEXT    = S_NEXT,
        ST_DONE    = S_DONE,
        ST_ERR     = S_ERR
    } state_e;

    // Phase-pulse vector bit positions
    localparam int P_FILL     = 0;
    localparam int P_DRAIN    = 1;
    localparam int P_ACTIVE   = 2;
    localparam int NUM_PULSES = 3;

    // Status vector bit positions
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_ERROR = 2;
    localparam int NUM_STAT   = 3;

    // Base-address register slots
    localparam int B_IN      = 0;
    localparam int B_W       = 1;
    localparam int B_OUT     = 2;
    localparam int NUM_BASES = 3;

    function automatic logic is_wait_state(input state_e s);
        return (s == ST_FILL) || (s == ST_LOAD) || (s == ST_COMPUTE);
    endfunction

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/matmul_sequencer_watchdog.sv
// Clearable saturating up-counter; tc flags the last permitted cycle of a
// wait phase so the sequencer can bail out after exactly TIMEOUT cycles.
module seq_watchdog
    import matmul_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tc = enable && (count_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !tc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Multi-tile matmul sequencer: one start/done handshake drives the fill/load/
// compute phases of the systolic datapath, striding base addresses per tile.
module matmul_sequencer
    import matmul_sequencer_pkg::*;
#(
    parameter int WIDTH_HEIGHT = 16,
    parameter int ADDR_W       = 8,
    parameter int TILE_W       = 8,
    parameter int TIMEOUT      = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic              abort,
    input  logic              mem_to_fifo_done,
    input  logic              fifo_to_arr_done,
    input  logic              output_done,
    output logic              fill_fifo,
    output logic              drain_fifo,
    output logic              active,
    output logic [ADDR_W-1:0] inputMem_rd_addr_base,
    output logic [ADDR_W-1:0] weightMem_rd_addr_base,
    output logic [ADDR_W-1:0] outputMem_wr_addr_base,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [TILE_W-1:0] tile_idx
);

    localparam int BASES_W = NUM_BASES * ADDR_W;

    state_e                  state_q, state_d;
    logic [NUM_PULSES-1:0]   pulse_q, pulse_d;
    logic [NUM_STAT-1:0]     stat_q, stat_d;
    logic [BASES_W-1:0]      base_q, base_d;
    logic [TILE_W-1:0]       tile_q, tile_d;
    logic [TILE_W-1:0]       num_q, num_d;
    logic [TILE_W-1:0]       tile_inc;
    logic                    wd_clear;
    logic                    wd_tc;

    assign tile_inc = tile_q + TILE_W'(1);
    assign wd_clear = (state_d != state_q);

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (is_wait_state(state_q)),
        .tc     (wd_tc)
    );

    always_comb begin
        state_d           = state_q;
        pulse_d           = '0;
        stat_d            = stat_q;
        stat_d[STAT_DONE] = 1'b0;
        base_d            = base_q;
        tile_d            = tile_q;
        num_d             = num_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_d                                = num_tiles;
                    base_d[B_IN*ADDR_W  +: ADDR_W]       = in_base;
                    base_d[B_W*ADDR_W   +: ADDR_W]       = w_base;
                    base_d[B_OUT*ADDR_W +: ADDR_W]       = out_base;
                    tile_d                               = '0;
                    stat_d[STAT_ERROR]                   = 1'b0;
                    stat_d[STAT_BUSY]                    = 1'b1;
                    if (num_tiles == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d         = ST_FILL;
                        pulse_d[P_FILL] = 1'b1;
                    end
                end
            end
            // A phase-done input wins over the watchdog if both land together.
            ST_FILL: begin
                if (mem_to_fifo_done) begin
                    state_d          = ST_LOAD;
                    pulse_d[P_DRAIN] = 1'b1;
                end else if (wd_tc) begin
                    state_d = ST_ERR;
                end
            end
            ST_LOAD: begin
                if (fifo_to_arr_done) begin
                    state_d           = ST_COMPUTE;
                    pulse_d[P_ACTIVE] = 1'b1;
                end else if (wd_tc) begin
                    state_d = ST_ERR;
                end
            end
            ST_COMPUTE: begin
                if (output_done) begin
                    state_d = ST_NEXT;
                end else if (wd_tc) begin
                    state_d = ST_ERR;
                end
            end
            ST_NEXT: begin
                for (int i = 0; i < NUM_BASES; i++) begin
                    base_d[i*ADDR_W +: ADDR_W] = base_q[i*ADDR_W +: ADDR_W] + ADDR_W'(WIDTH_HEIGHT);
                end
                tile_d = tile_inc;
                if (tile_inc == num_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d         = ST_FILL;
                    pulse_d[P_FILL] = 1'b1;
                end
            end
            ST_DONE: begin
                stat_d[STAT_DONE] = 1'b1;
                stat_d[STAT_BUSY] = 1'b0;
                state_d           = ST_IDLE;
            end
            ST_ERR: begin
                stat_d[STAT_ERROR] = 1'b1;
                stat_d[STAT_BUSY]  = 1'b0;
                state_d            = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort freezes bases/tile where they are and leaves done/error alone.
        if (abort && (state_q != ST_IDLE)) begin
            state_d            = ST_IDLE;
            pulse_d            = '0;
            stat_d[STAT_BUSY]  = 1'b0;
            stat_d[STAT_DONE]  = 1'b0;
            stat_d[STAT_ERROR] = stat_q[STAT_ERROR];
            base_d             = base_q;
            tile_d             = tile_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pulse_q <= '0;
            stat_q  <= '0;
            tile_q  <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            stat_q  <= stat_d;
            tile_q  <= tile_d;
            num_q   <= num_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BASES; gi++) begin : g_base
            logic [ADDR_W-1:0] slice_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    slice_q <= '0;
                end else begin
                    slice_q <= base_d[gi*ADDR_W +: ADDR_W];
                end
            end
            assign base_q[gi*ADDR_W +: ADDR_W] = slice_q;
        end
    endgenerate

    assign fill_fifo              = pulse_q[P_FILL];
    assign drain_fifo             = pulse_q[P_DRAIN];
    assign active                 = pulse_q[P_ACTIVE];
    assign busy                   = stat_q[STAT_BUSY];
    assign done                   = stat_q[STAT_DONE];
    assign error                  = stat_q[STAT_ERROR];
    assign tile_idx               = tile_q;
    assign inputMem_rd_addr_base  = base_q[B_IN*ADDR_W  +: ADDR_W];
    assign weightMem_rd_addr_base = base_q[B_W*ADDR_W   +: ADDR_W];
    assign outputMem_wr_addr_base = base_q[B_OUT*ADDR_W +: ADDR_W];

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: jobs queue their expected event
// stream; a monitor pops and compares on every pulse, done or error rise.
module tb_matmul_sequencer;

    localparam int WH = 16;
    localparam int AW = 8;
    localparam int TW = 8;
    localparam int TO = 1024;

    localparam int EV_FILL   = 0;
    localparam int EV_DRAIN  = 1;
    localparam int EV_ACTIVE = 2;
    localparam int EV_DONE   = 3;
    localparam int EV_ERR    = 4;

    localparam int M_NORMAL  = 0;
    localparam int M_TIMEOUT = 1;
    localparam int M_ABORT   = 2;
    localparam int M_RESTART = 3;
    localparam int M_RESET   = 4;
    localparam int M_ABSTART = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [TW-1:0] num_tiles;
    logic [AW-1:0] in_base, w_base, out_base;
    logic          abort;
    logic          mem_to_fifo_done, fifo_to_arr_done, output_done;
    logic          fill_fifo, drain_fifo, active;
    logic [AW-1:0] inputMem_rd_addr_base, weightMem_rd_addr_base, outputMem_wr_addr_base;
    logic          busy, done, error;
    logic [TW-1:0] tile_idx;

    matmul_sequencer #(
        .WIDTH_HEIGHT (WH),
        .ADDR_W       (AW),
        .TILE_W       (TW),
        .TIMEOUT      (TO)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .num_tiles              (num_tiles),
        .in_base                (in_base),
        .w_base                 (w_base),
        .out_base               (out_base),
        .abort                  (abort),
        .mem_to_fifo_done       (mem_to_fifo_done),
        .fifo_to_arr_done       (fifo_to_arr_done),
        .output_done            (output_done),
        .fill_fifo              (fill_fifo),
        .drain_fifo             (drain_fifo),
        .active                 (active),
        .inputMem_rd_addr_base  (inputMem_rd_addr_base),
        .weightMem_rd_addr_base (weightMem_rd_addr_base),
        .outputMem_wr_addr_base (outputMem_wr_addr_base),
        .busy                   (busy),
        .done                   (done),
        .error                  (error),
        .tile_idx               (tile_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int tile;
        int ib;
        int wb;
        int ob;
    } ev_t;

    ev_t  exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   job_no   = 0;
    bit   mon_en   = 1'b0;
    logic err_prev = 1'b0;

    function automatic ev_t mk_ev(input int kind, input int tile, input int ib, input int wb, input int ob);
        ev_t e;
        e.kind = kind;
        e.tile = tile % 256;
        e.ib   = (ib + WH * tile) % 256;
        e.wb   = (wb + WH * tile) % 256;
        e.ob   = (ob + WH * tile) % 256;
        return e;
    endfunction

    task automatic check_ev(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got kind=%0d tile=%0d required no event", kind, tile_idx);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.tile != int'(tile_idx) || e.ib != int'(inputMem_rd_addr_base) ||
                e.wb != int'(weightMem_rd_addr_base) || e.ob != int'(outputMem_wr_addr_base) ||
                ((kind == EV_DONE || kind == EV_ERR) && busy)) begin
                failures++;
                $display("FAIL event got kind=%0d tile=%0d bases=%0d/%0d/%0d busy=%0b required kind=%0d tile=%0d bases=%0d/%0d/%0d",
                         kind, tile_idx, inputMem_rd_addr_base, weightMem_rd_addr_base, outputMem_wr_addr_base, busy,
                         e.kind, e.tile, e.ib, e.wb, e.ob);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (fill_fifo)          check_ev(EV_FILL);
            if (drain_fifo)         check_ev(EV_DRAIN);
            if (active)             check_ev(EV_ACTIVE);
            if (done)               check_ev(EV_DONE);
            if (error && !err_prev) check_ev(EV_ERR);
        end
        err_prev = error;
    end

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, want);
        end
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            EV_FILL:   return fill_fifo;
            EV_DRAIN:  return drain_fifo;
            EV_ACTIVE: return active;
            default:   return done;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sig_of(which)) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL wait_event kind=%0d got=timeout required=seen within %0d cycles", which, budget);
    endtask

    task automatic respond(input int which, input int dly);
        int d;
        d = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
        repeat (d) @(negedge clk);
        case (which)
            EV_FILL:  mem_to_fifo_done = 1'b1;
            EV_DRAIN: fifo_to_arr_done = 1'b1;
            default:  output_done      = 1'b1;
        endcase
        @(negedge clk);
        mem_to_fifo_done = 1'b0;
        fifo_to_arr_done = 1'b0;
        output_done      = 1'b0;
    endtask

    task automatic resync();
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic run_job(input int n, input int ib, input int wb, input int ob,
                           input int mode, input int k, input int dly);
        bit ok;
        int cnt;
        for (int t = 0; t < n; t++) begin
            exp_q.push_back(mk_ev(EV_FILL, t, ib, wb, ob));
            exp_q.push_back(mk_ev(EV_DRAIN, t, ib, wb, ob));
            if (mode == M_TIMEOUT && t == k) begin
                exp_q.push_back(mk_ev(EV_ERR, t, ib, wb, ob));
                break;
            end
            exp_q.push_back(mk_ev(EV_ACTIVE, t, ib, wb, ob));
            if ((mode == M_ABORT || mode == M_RESET) && t == k) break;
            if (t == n - 1) exp_q.push_back(mk_ev(EV_DONE, n, ib, wb, ob));
        end
        if (n == 0) exp_q.push_back(mk_ev(EV_DONE, 0, ib, wb, ob));

        @(negedge clk);
        if (mode == M_ABSTART) begin
            abort = 1'b1;
            @(negedge clk);
        end
        num_tiles = TW'(n);
        in_base   = AW'(ib);
        w_base    = AW'(wb);
        out_base  = AW'(ob);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_val("busy_after_start", int'(busy), 1);
        check_val("error_cleared_by_start", int'(error), 0);

        if (n == 0) begin
            @(negedge clk);
            check_val("done_two_cycles_after_start", int'(done), 1);
        end

        for (int t = 0; t < n; t++) begin
            wait_sig(EV_FILL, 40, ok);
            if (!ok) begin resync(); return; end
            if (mode == M_RESTART && t == k) begin
                num_tiles = 8'd0;
                in_base   = AW'($urandom_range(0, 255));
                start     = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check_val("busy_hold_on_restart", int'(busy), 1);
                check_val("tile_hold_on_restart", int'(tile_idx), t);
            end
            respond(EV_FILL, dly);

            wait_sig(EV_DRAIN, 40, ok);
            if (!ok) begin resync(); return; end
            if (mode == M_TIMEOUT && t == k) begin
                cnt = 0;
                while (!error && cnt < 2 * TO) begin
                    @(negedge clk);
                    cnt++;
                end
                checks++;
                if (cnt < TO || cnt > TO + 2) begin
                    failures++;
                    $display("FAIL timeout_latency got=%0d required=%0d..%0d", cnt, TO, TO + 2);
                end
                check_val("busy_low_on_error", int'(busy), 0);
                repeat (5) @(negedge clk);
                check_val("error_sticky", int'(error), 1);
                break;
            end
            respond(EV_DRAIN, dly);

            wait_sig(EV_ACTIVE, 40, ok);
            if (!ok) begin resync(); return; end
            if (mode == M_ABORT && t == k) begin
                repeat (2) @(negedge clk);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check_val("busy_low_after_abort", int'(busy), 0);
                repeat (3) @(negedge clk);
                output_done = 1'b1;
                @(negedge clk);
                output_done = 1'b0;
                repeat (8) @(negedge clk);
                check_val("busy_low_after_late_done", int'(busy), 0);
                break;
            end
            if (mode == M_RESET && t == k) begin
                repeat (2) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                check_val("outputs_zero_after_reset",
                          int'({fill_fifo, drain_fifo, active, busy, done, error, tile_idx,
                                inputMem_rd_addr_base, weightMem_rd_addr_base, outputMem_wr_addr_base} != '0), 0);
                reset = 1'b0;
                exp_q.delete();
                repeat (2) @(negedge clk);
                break;
            end
            respond(EV_ACTIVE, dly);
        end

        if (n > 0 && (mode == M_NORMAL || mode == M_RESTART || mode == M_ABSTART)) begin
            wait_sig(EV_DONE, 20, ok);
            if (!ok) begin resync(); return; end
            @(negedge clk);
        end
        @(negedge clk);
        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("job %0d tiles=%0d bases=%0d/%0d/%0d mode=%0d k=%0d checks=%0d failures=%0d",
                 job_no, n, ib, wb, ob, mode, k, checks, failures);
        job_no++;
    endtask

    initial begin
        int n;
        int mode;
        reset            = 1'b1;
        start            = 1'b0;
        abort            = 1'b0;
        num_tiles        = '0;
        in_base          = '0;
        w_base           = '0;
        out_base         = '0;
        mem_to_fifo_done = 1'b0;
        fifo_to_arr_done = 1'b0;
        output_done      = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs_zero",
                  int'({fill_fifo, drain_fifo, active, busy, done, error, tile_idx,
                        inputMem_rd_addr_base, weightMem_rd_addr_base, outputMem_wr_addr_base} != '0), 0);
        reset = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("idle_abort_ignored_busy", int'(busy), 0);
        mon_en = 1'b1;

        run_job(1, 0, 0, 0, M_NORMAL, 0, 5);
        check_val("base_after_one_tile", int'(inputMem_rd_addr_base), 16);
        run_job(3, 240, 17, 100, M_NORMAL, 0, -1);
        run_job(0, 33, 44, 55, M_NORMAL, 0, -1);
        run_job(2, 8, 9, 10, M_TIMEOUT, 1, -1);
        run_job(2, 1, 2, 3, M_NORMAL, 0, 0);
        run_job(3, 50, 60, 70, M_ABORT, 1, -1);
        run_job(2, 200, 210, 220, M_RESTART, 0, -1);
        run_job(2, 5, 6, 7, M_RESET, 0, -1);
        run_job(2, 11, 22, 33, M_ABSTART, 0, -1);

        for (int j = 0; j < 20; j++) begin
            n = $urandom_range(1, 5);
            case ($urandom_range(0, 3))
                0:       mode = M_ABORT;
                1:       mode = M_RESTART;
                default: mode = M_NORMAL;
            endcase
            run_job(n, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    mode, $urandom_range(0, n - 1), -1);
        end

        run_job(255, 7, 130, 250, M_NORMAL, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
